// File: rtl/ili9341_reader.sv
// ILI9341 8080-I read engine: one command byte, bus turnaround, then N read strobes.
// Define ILI9341_RD_DUMMY_DROP_EN to suppress the response for the first (dummy) strobe.
module ili9341_reader #(
    parameter int unsigned WR_LOW_TICKS  = 1,
    parameter int unsigned WR_HIGH_TICKS = 1,
    parameter int unsigned TURN_TICKS    = 2,
    parameter int unsigned RD_LOW_TICKS  = 6,
    parameter int unsigned RD_HIGH_TICKS = 2
) (
    input  logic       clk_16MHz,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [4:0] req_len,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       busy,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       ncs,
    output logic       cmd_data,
    output logic       nwr,
    output logic       nrd,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din
);

    // Terminal tick-counter value for a phase; 0 behaves as 1, values clamp to the 4-bit range.
    function automatic logic [3:0] tick_limit(input int unsigned ticks);
        if (ticks <= 1) return 4'd0;
        if (ticks >= 15) return 4'd14;
        return 4'(ticks - 1);
    endfunction

    localparam logic [3:0] WrLowLim  = tick_limit(WR_LOW_TICKS);
    localparam logic [3:0] WrHighLim = tick_limit(WR_HIGH_TICKS);
    localparam logic [3:0] TurnLim   = tick_limit(TURN_TICKS);
    localparam logic [3:0] RdLowLim  = tick_limit(RD_LOW_TICKS);
    localparam logic [3:0] RdHighLim = tick_limit(RD_HIGH_TICKS);

    typedef enum logic [3:0] {
        StIdle,
        StArb,
        StCmdSetup,
        StCmdLow,
        StCmdHigh,
        StTurn,
        StRdLow,
        StRdHigh,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  tick_q;
    logic [4:0]  rd_cnt_q;
    logic [4:0]  len_q;
    logic [7:0]  cmd_q;
    logic [7:0]  data_q;
    logic        is_dummy;

`ifdef ILI9341_RD_DUMMY_DROP_EN
    assign is_dummy = (rd_cnt_q == 5'd1);
`else
    assign is_dummy = 1'b0;
`endif

    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (req_valid) state_d = StArb;
            StArb:      if (bus_gnt) state_d = StCmdSetup;
            StCmdSetup: state_d = StCmdLow;
            StCmdLow:   if (tick_q == WrLowLim) state_d = StCmdHigh;
            StCmdHigh: begin
                if (tick_q == WrHighLim) state_d = (len_q == 5'd0) ? StDone : StTurn;
            end
            StTurn:     if (tick_q == TurnLim) state_d = StRdLow;
            StRdLow:    if (tick_q == RdLowLim) state_d = StRdHigh;
            StRdHigh: begin
                if (tick_q == RdHighLim) state_d = (rd_cnt_q == len_q) ? StDone : StRdLow;
            end
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Tick counter restarts on every state change; rd_cnt_q counts strobes already sampled.
    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            tick_q   <= 4'd0;
            rd_cnt_q <= 5'd0;
            len_q    <= 5'd0;
            cmd_q    <= 8'd0;
            data_q   <= 8'd0;
        end else begin
            tick_q <= (state_d != state_q) ? 4'd0 : tick_q + 4'd1;
            if (state_q == StIdle && req_valid) begin
                cmd_q    <= req_cmd;
                len_q    <= req_len;
                rd_cnt_q <= 5'd0;
            end
            if (state_q == StRdLow && tick_q == RdLowLim) begin
                data_q   <= din;
                rd_cnt_q <= rd_cnt_q + 5'd1;
            end
        end
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        bus_req   = 1'b1;
        ncs       = 1'b0;
        cmd_data  = 1'b1;
        nwr       = 1'b1;
        nrd       = 1'b1;
        dout      = 8'd0;
        dout_oe   = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                bus_req   = 1'b0;
                ncs       = 1'b1;
            end
            StArb: ncs = 1'b1;
            StCmdSetup, StCmdHigh: begin
                cmd_data = 1'b0;
                dout     = cmd_q;
                dout_oe  = 1'b1;
            end
            StCmdLow: begin
                cmd_data = 1'b0;
                dout     = cmd_q;
                dout_oe  = 1'b1;
                nwr      = 1'b0;
            end
            StTurn: ;
            StRdLow: nrd = 1'b0;
            StRdHigh: begin
                if (tick_q == 4'd0 && !is_dummy) begin
                    rsp_valid = 1'b1;
                    rsp_last  = (rd_cnt_q == len_q);
                end
            end
            StDone: begin
                ncs     = 1'b1;
                bus_req = 1'b0;
            end
            default: ;
        endcase
    end

    assign rsp_data = data_q;

endmodule

// File: tb/tb_ili9341_reader.sv
// Self-checking bench for ili9341_reader: a pin recorder plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_ili9341_reader;

`ifdef ILI9341_RD_DUMMY_DROP_EN
    localparam bit DropDummy = 1'b1;
`else
    localparam bit DropDummy = 1'b0;
`endif

    logic       clk_16MHz = 1'b0;
    logic       resetn, req_valid, req_ready, rsp_valid, rsp_last, busy, bus_req, bus_gnt;
    logic       ncs, cmd_data, nwr, nrd, dout_oe;
    logic [7:0] req_cmd, rsp_data, dout, din;
    logic [4:0] req_len;

    ili9341_reader dut (
        .clk_16MHz(clk_16MHz), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .ncs(ncs), .cmd_data(cmd_data),
        .nwr(nwr), .nrd(nrd), .dout(dout), .dout_oe(dout_oe), .din(din)
    );

    initial forever #31.25 clk_16MHz = ~clk_16MHz;

    int checks = 0;
    int errors = 0;

    // Recorder state (written only by the recorder process)
    int         nrd_falls, nwr_falls, nwr_low_w, ncs_rises, turn_cyc, cd_low_cyc, wr_high_cyc;
    int         arb_cyc, arb_bad, oe_bad, low_run, high_run;
    int         rd_low_w[$];
    int         rd_high_w[$];
    logic [7:0] rsp_d[$];
    bit         rsp_l[$];
    logic [7:0] cmd_seen;
    bit         rec_clear = 1'b0;
    bit         nrd_p, nwr_p, ncs_p;
    logic [7:0] din_bytes[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pin recorder and panel read-data model: samples on the falling clock edge.
    initial begin
        nrd_p = 1'b1; nwr_p = 1'b1; ncs_p = 1'b1; din = 8'd0;
        forever begin
            @(negedge clk_16MHz);
            if (rec_clear) begin
                nrd_falls = 0; nwr_falls = 0; nwr_low_w = 0; ncs_rises = 0; turn_cyc = 0;
                cd_low_cyc = 0; wr_high_cyc = 0; arb_cyc = 0; arb_bad = 0; oe_bad = 0;
                low_run = 0; high_run = 0; cmd_seen = 8'd0;
                rd_low_w.delete(); rd_high_w.delete(); rsp_d.delete(); rsp_l.delete();
            end
            if (nrd == 1'b0) begin
                if (nrd_p) begin
                    nrd_falls++;
                    if (nrd_falls > 1) rd_high_w.push_back(high_run);
                    low_run = 0;
                end
                low_run++;
                // Panel output is not yet valid in the first low cycle
                din = (low_run == 1) ? ~din_bytes[(nrd_falls - 1) & 31]
                                     : din_bytes[(nrd_falls - 1) & 31];
            end else begin
                if (!nrd_p) begin
                    rd_low_w.push_back(low_run);
                    high_run = 0;
                end
                high_run++;
            end
            if (nwr == 1'b0) begin
                if (nwr_p) nwr_falls++;
                nwr_low_w++;
                cmd_seen = dout;
                if (!dout_oe || cmd_data) oe_bad++;
            end
            if (ncs && !ncs_p) ncs_rises++;
            if (!ncs && !dout_oe && nrd && nrd_falls == 0) turn_cyc++;
            if (!cmd_data) cd_low_cyc++;
            if (!ncs && !cmd_data && nwr && nwr_falls > 0) wr_high_cyc++;
            if (bus_req && ncs) begin
                arb_cyc++;
                if (!nwr || !nrd || req_ready || !busy) arb_bad++;
            end
            if (rsp_valid) begin
                rsp_d.push_back(rsp_data);
                rsp_l.push_back(rsp_last);
            end
            nrd_p = nrd; nwr_p = nwr; ncs_p = ncs;
        end
    end

    task automatic clear_rec();
        @(posedge clk_16MHz); #1 rec_clear = 1'b1;
        @(posedge clk_16MHz); #1 rec_clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk_16MHz); #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic launch(input logic [7:0] cmd, input logic [4:0] len);
        clear_rec();
        req_cmd = cmd; req_len = len; req_valid = 1'b1;
        @(posedge clk_16MHz); #1;
        req_valid = 1'b0;
        req_cmd = 8'($urandom);
        req_len = 5'($urandom);
    endtask

    // Reference model: expected responses from the strobe list, then pin-level counts.
    task automatic check_txn(input logic [7:0] cmd, input int len);
        logic [7:0] ed[$];
        bit         el[$];
        for (int i = 0; i < len; i++) begin
            if (!(DropDummy && i == 0)) begin
                ed.push_back(din_bytes[i]);
                el.push_back(i == len - 1);
            end
        end
        check("rsp_count", rsp_d.size(), ed.size());
        for (int i = 0; i < ed.size() && i < rsp_d.size(); i++) begin
            check($sformatf("rsp_data[%0d]", i), {24'd0, rsp_d[i]}, {24'd0, ed[i]});
            check($sformatf("rsp_last[%0d]", i), {31'd0, rsp_l[i]}, {31'd0, el[i]});
        end
        check("nrd_falls", nrd_falls, len);
        check("nwr_falls", nwr_falls, 1);
        check("cmd_byte", {24'd0, cmd_seen}, {24'd0, cmd});
        check("ncs_rises", ncs_rises, 1);
        check("wr_phase_bus", oe_bad, 0);
        check("nwr_low_width", nwr_low_w, 1);
        check("nwr_high_width", wr_high_cyc, 1);
        check("cmd_data_low_cycles", cd_low_cyc, 3);
        check("turn_cycles", turn_cyc, (len > 0) ? 2 : 0);
        check("rd_low_count", rd_low_w.size(), len);
        foreach (rd_low_w[i]) check($sformatf("rd_low_width[%0d]", i), rd_low_w[i], 6);
        check("rd_high_count", rd_high_w.size(), (len > 0) ? len - 1 : 0);
        foreach (rd_high_w[i]) check($sformatf("rd_high_width[%0d]", i), rd_high_w[i], 2);
    endtask

    initial begin
        int n;
        int rcount;
        logic [7:0] cmd;
        int len;

        resetn = 1'b0; req_valid = 1'b0; req_cmd = 8'd0; req_len = 5'd0; bus_gnt = 1'b1;
        foreach (din_bytes[i]) din_bytes[i] = 8'd0;
        repeat (3) @(posedge clk_16MHz);
        #1;
        check("reset_pins", {23'd0, ncs, nwr, nrd, cmd_data, dout_oe, bus_req, rsp_valid, rsp_last, busy},
              32'b1_1110_0000);
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        resetn = 1'b1;
        @(posedge clk_16MHz); #1;
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        // Panel ID read (0xD3)
        din_bytes[0] = 8'hFF; din_bytes[1] = 8'h00; din_bytes[2] = 8'h93; din_bytes[3] = 8'h41;
        launch(8'hD3, 5'd4);
        wait_idle(600);
        check_txn(8'hD3, 4);

        // Randomised reads
        for (int t = 0; t < 6; t++) begin
            cmd = 8'($urandom);
            len = int'($urandom_range(1, 6));
            foreach (din_bytes[i]) din_bytes[i] = 8'($urandom);
            launch(cmd, 5'(len));
            wait_idle(600);
            check_txn(cmd, len);
        end

        // Zero-length read; a request held while busy must be ignored
        launch(8'h2E, 5'd0);
        req_valid = 1'b1; req_cmd = 8'h55; req_len = 5'd3;
        check("busy_not_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk_16MHz); #1;
        check("busy_not_ready2", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        wait_idle(100);
        repeat (5) @(posedge clk_16MHz);
        #1;
        check_txn(8'h2E, 0);
        check("stays_idle", {31'd0, busy}, 32'd0);

        // Arbitration: grant withheld for 20 cycles
        bus_gnt = 1'b0;
        foreach (din_bytes[i]) din_bytes[i] = 8'($urandom);
        launch(8'h09, 5'd2);
        repeat (20) @(posedge clk_16MHz);
        #1;
        check("arb_bus_req", {31'd0, bus_req}, 32'd1);
        check("arb_cycles", arb_cyc, 20);
        check("arb_idle_pins", arb_bad, 0);
        bus_gnt = 1'b1;
        @(posedge clk_16MHz); #1;
        check("cmd_after_gnt", {29'd0, ncs, cmd_data, dout_oe}, 32'b001);
        check("cmd_after_gnt_dout", {24'd0, dout}, 32'h09);
        wait_idle(600);
        check_txn(8'h09, 2);

        // Reset during the second read strobe
        foreach (din_bytes[i]) din_bytes[i] = 8'($urandom);
        launch(8'h2E, 5'd4);
        n = 0;
        while (nrd_falls < 2 && n < 200) begin
            @(posedge clk_16MHz); #1;
            n++;
        end
        check("second_strobe_reached", nrd_falls, 2);
        check("second_strobe_low", {31'd0, nrd}, 32'd0);
        rcount = rsp_d.size();
        resetn = 1'b0;
        @(posedge clk_16MHz); #1;
        check("midreset_pins", {27'd0, ncs, nrd, dout_oe, bus_req, rsp_valid}, 32'b11000);
        resetn = 1'b1;
        repeat (20) @(posedge clk_16MHz);
        #1;
        check("midreset_no_more_rsp", rsp_d.size(), rcount);
        check("midreset_no_last", {31'd0, (rsp_l.sum() with (int'(item))) != 0}, 32'd0);
        check("midreset_ready", {30'd0, req_ready, busy}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ili9341_reader.md
Name: ili9341_reader

Overview:
- Read-side companion to the ILI9341 8080-I 8-bit parallel write driver.
- Issues one read command byte, turns the bus around, then performs N read strobes. Each sampled byte is returned on a single-cycle response strobe.
- Used for panel ID probing (0x04, 0xD3), status reads (0x09, 0x0A) and GRAM readback (0x2E).
- Shares the panel bus with the write driver through a bus_req/bus_gnt arbiter handshake.

Parameters:
- WR_LOW_TICKS, 1, cycles nwr held low for the command byte (62.5 ns each).
- WR_HIGH_TICKS, 1, cycles nwr held high after the command byte.
- TURN_TICKS, 2, cycles between releasing dout and the first nrd fall.
- RD_LOW_TICKS, 6, cycles nrd held low per byte (375 ns ≥ tRDL 355 ns).
- RD_HIGH_TICKS, 2, cycles nrd held high per byte (125 ns ≥ tRDH 90 ns).

Ports:
- clk_16MHz  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  read request.
- req_ready  out  1  high in IDLE only.
- req_cmd  in  8  command byte to issue.
- req_len  in  5  number of read strobes (0..31).
- rsp_valid  out  1  one-cycle pulse per returned byte; no backpressure.
- rsp_data  out  8  returned byte.
- rsp_last  out  1  qualifies the final rsp_valid of a request.
- busy  out  1  high in any state other than IDLE.
- bus_req  out  1  request panel bus ownership.
- bus_gnt  in  1  arbiter grant.
- ncs  out  1  chip select, active-low.
- cmd_data  out  1  1 = data, 0 = command.
- nwr  out  1  write strobe, active-low; panel latches on the rising edge.
- nrd  out  1  read strobe, active-low; panel drives data while low.
- dout  out  8  bus drive value.
- dout_oe  out  1  bus output enable for the top-level tristate.
- din  in  8  bus input, already synchronised at top level.

Behaviour:
- Reset (resetn low at a clk edge): state=IDLE. Outputs take these values:
  - ncs=1, nwr=1, nrd=1, cmd_data=1, dout=0, dout_oe=0.
  - bus_req=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0.
  - All counters cleared.
- Reset mid-transaction: the same values apply at that edge. The bus is released immediately and the in-flight response is abandoned; no rsp_last is issued.
- Tick parameters valid range 1..15; a value of 0 behaves as 1. Tick counter is 4 bits; byte counter is 5 bits.
- IDLE: req_ready=1. When req_valid&req_ready, latch req_cmd/req_len, then ARB.
- ARB: bus_req=1. bus_gnt is sampled only in this state. When gnt=1, go to CMD_SETUP.
  - The arbiter must not revoke the grant before bus_req falls.
- CMD_SETUP (1 cycle): ncs=0, cmd_data=0, dout=cmd, dout_oe=1.
- CMD_LOW: nwr=0 for WR_LOW_TICKS.
- CMD_HIGH: nwr=1 for WR_HIGH_TICKS, then:
  - latched len==0 → DONE;
  - otherwise → TURN.
- TURN: dout_oe=0, cmd_data=1, for TURN_TICKS.
- RD_LOW: nrd=0 for RD_LOW_TICKS. din is captured at the clock edge that ends the last RD_LOW cycle, coincident with nrd rising.
- RD_HIGH: nrd=1 for RD_HIGH_TICKS.
  - rsp_valid/rsp_data are asserted in the first RD_HIGH cycle.
  - rsp_last=1 on that pulse when it is the final byte.
  - After RD_HIGH: another byte remains → RD_LOW; otherwise → DONE.
- DONE (1 cycle): ncs=1, bus_req=0, dout_oe=0. Next state is IDLE, so req_ready returns to 1 exactly 1 cycle after DONE.
- Requests arriving while busy are not accepted. Request fields are sampled only at acceptance; later changes are ignored.
- Per-byte read period = RD_LOW_TICKS + RD_HIGH_TICKS cycles (default 8 = 500 ns).
- ncs stays low continuously from CMD_SETUP through the last RD_HIGH; it is not deasserted between bytes.

Optional Feature:
- Macro: ILI9341_RD_DUMMY_DROP_EN.
- Defined: the first read strobe of each request is performed but produces no rsp_valid (ILI9341 dummy-read byte).
  - req_len counts all strobes including the dummy.
  - req_len==1 produces no response at all; the transaction still completes and returns to IDLE.
  - rsp_last is on the last non-dummy byte.
- Undefined: every strobe produces rsp_valid, and rsp_last is on strobe req_len.

Test Plan:
- ID read, macro defined: req_cmd=0xD3, req_len=4; bench din per strobe 0xFF,0x00,0x93,0x41 → rsp 0x00,0x93,0x41, rsp_last with 0x41; exactly 4 nrd falls; ncs low throughout.
- Same stimulus, macro undefined → 4 rsp pulses 0xFF,0x00,0x93,0x41, last on 0x41.
- Strobe timing (defaults): nwr low 1 cycle, then 1 high, then dout_oe=0 for 2 cycles before the first nrd fall; nrd low 6 / high 2 cycles per byte; cmd_data=0 only around the command byte.
- Arbitration: hold bus_gnt=0 for 20 cycles after acceptance → bus_req=1, ncs=1, nwr/nrd idle and req_ready=0 throughout; command starts the cycle after gnt=1.
- req_len=0, req_cmd=0x2E → one nwr pulse with dout=0x2E, no nrd activity, no rsp_valid, return to IDLE; req_valid asserted while busy is not accepted.
- resetn low during the 2nd RD_LOW of a len=4 request → next edge shows ncs=1, nrd=1, dout_oe=0, bus_req=0, no further rsp_valid, req_ready=1 after release.
